hazard_ctrl: RTL

Pipeline sequencing controller for the five-stage MIPS core. It owns every latch enable and flush for the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and produces the execute stage's operand forwarding (srcA/srcB, forA/forB). It resolves cache waits, load-use hazards, taken branches and end-of-program halt drain. It also keeps stall and flush performance counters.

---
 rtl/cpu_types_pkg.sv | 23 ++
 rtl/forward_unit.sv | 53 +++++
 rtl/hazard_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the five-stage core: data word, register index and the
// hazard controller's sequencing states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hzstate_t;

  localparam regbits_t REG_ZERO = 5'd0;

  // True when a producing stage writes the register a consumer reads.
  // Register $0 is hardwired to zero and is never a forwarding source.
  function automatic logic reg_match(input logic wr, input regbits_t wsel,
                                     input regbits_t rsel);
    return wr && (wsel != REG_ZERO) && (wsel == rsel);
  endfunction

endpackage

// File: rtl/forward_unit.sv
// Execute-stage operand forwarding: selects MEM-stage ALU result or WB-stage
// write data for each EX source register, MEM taking priority.
module forward_unit
  import cpu_types_pkg::*;
(
  input  regbits_t ex_rs,
  input  regbits_t ex_rt,
  input  regbits_t mem_wsel,
  input  logic     mem_regWr,
  input  logic     mem_dREN,
  input  word_t    mem_aluout,
  input  regbits_t wb_wsel,
  input  logic     wb_regWr,
  input  word_t    wb_wdat,
  output logic     srcA,
  output logic     srcB,
  output word_t    forA,
  output word_t    forB
);

  logic mem_a, mem_b, wb_a, wb_b;

  // A load in MEM has no data yet; its value is picked up from WB next cycle.
  assign mem_a = reg_match(mem_regWr & ~mem_dREN, mem_wsel, ex_rs);
  assign mem_b = reg_match(mem_regWr & ~mem_dREN, mem_wsel, ex_rt);
  assign wb_a  = reg_match(wb_regWr, wb_wsel, ex_rs);
  assign wb_b  = reg_match(wb_regWr, wb_wsel, ex_rt);

  always_comb begin
    srcA = 1'b0;
    forA = '0;
    if (mem_a) begin
      srcA = 1'b1;
      forA = mem_aluout;
    end else if (wb_a) begin
      srcA = 1'b1;
      forA = wb_wdat;
    end
  end

  always_comb begin
    srcB = 1'b0;
    forB = '0;
    if (mem_b) begin
      srcB = 1'b1;
      forB = mem_aluout;
    end else if (wb_b) begin
      srcB = 1'b1;
      forB = wb_wdat;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing for the five-stage core: latch enables, bubble flushes,
// halt drain and stall/flush performance counters.
//   state  | meaning
//   RUN    | normal issue, priority hazard decode active
//   DRAIN  | halt reached MEM and was written back; pipeline frozen one cycle
//   HALTED | core stopped, halt asserted until reset
module hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  regbits_t         id_rs,
  input  regbits_t         id_rt,
  input  logic             id_usesrs,
  input  logic             id_usesrt,
  input  regbits_t         ex_rs,
  input  regbits_t         ex_rt,
  input  regbits_t         ex_wsel,
  input  logic             ex_regWr,
  input  logic             ex_dREN,
  input  regbits_t         mem_wsel,
  input  logic             mem_regWr,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_halt,
  input  logic             br_taken,
  input  word_t            mem_aluout,
  input  regbits_t         wb_wsel,
  input  logic             wb_regWr,
  input  word_t            wb_wdat,
  output logic             ifen,
  output logic             iden,
  output logic             exen,
  output logic             memen,
  output logic             wben,
  output logic             idflush,
  output logic             exflush,
  output logic             memflush,
  output logic             srcA,
  output logic             srcB,
  output word_t            forA,
  output word_t            forB,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hzstate_t state;
  logic     dwait;
  logic     load_use;
  logic     any_stall;

  forward_unit u_fwd (
    .ex_rs      (ex_rs),
    .ex_rt      (ex_rt),
    .mem_wsel   (mem_wsel),
    .mem_regWr  (mem_regWr),
    .mem_dREN   (mem_dREN),
    .mem_aluout (mem_aluout),
    .wb_wsel    (wb_wsel),
    .wb_regWr   (wb_regWr),
    .wb_wdat    (wb_wdat),
    .srcA       (srcA),
    .srcB       (srcB),
    .forA       (forA),
    .forB       (forB)
  );

  assign dwait = (mem_dREN | mem_dWEN) & ~dhit;

  assign load_use = ex_dREN & ex_regWr & (ex_wsel != REG_ZERO) &
                    ((id_usesrs & (id_rs == ex_wsel)) |
                     (id_usesrt & (id_rt == ex_wsel)));

  always_comb begin
    ifen     = 1'b0;
    iden     = 1'b0;
    exen     = 1'b0;
    memen    = 1'b0;
    wben     = 1'b0;
    idflush  = 1'b0;
    exflush  = 1'b0;
    memflush = 1'b0;
    if (state == RUN) begin
      if (dwait) begin
        // full freeze until the data cache answers
      end else if (mem_halt) begin
        wben = 1'b1;
      end else if (br_taken) begin
        // PC redirect is taken even during an icache miss
        {ifen, iden, exen, memen, wben} = 5'b11111;
        {idflush, exflush, memflush}    = 3'b111;
      end else if (load_use) begin
        {exen, memen, wben} = 3'b111;
        exflush             = 1'b1;
      end else if (!ihit) begin
        {iden, exen, memen, wben} = 4'b1111;
        idflush                   = 1'b1;
      end else begin
        {ifen, iden, exen, memen, wben} = 5'b11111;
      end
    end
  end

  assign any_stall = ~(ifen & iden & exen & memen & wben);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= RUN;
      halt      <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (!dwait && mem_halt) state <= DRAIN;
          if (any_stall) stall_cnt <= stall_cnt + 1'b1;
          if (br_taken && !dwait) flush_cnt <= flush_cnt + 1'b1;
        end
        DRAIN: begin
          state <= HALTED;
          halt  <= 1'b1;
        end
        HALTED: state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

endmodule
